pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard controller for the in-order RISC-V pipeline, sitting between ID and EX/MEM. Detects load-use hazards and stalls IF/ID for a configurable load latency. Freezes the front end and ID/EX while a multi-cycle EX unit is busy. Flushes the younger instructions on a taken branch or jump resolved in EX. Successor of the single-cycle, purely combinational load-use stall logic.

## Interface
Parameters:
- REG_AW, 5, register address width
- LOAD_LAT, 1, stall cycles per load-use hazard (≥1; 1 = classic single bubble)
- PERF_W, 32, perf counter width (used only with HAZARD_PERF_CNT_EN)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, synchronous, active-low
- mem_en_ex  in  1  EX-stage instruction accesses memory
- mem_read_ex  in  1  EX-stage instruction is a load
- rd_ex  in  REG_AW  EX-stage destination register
- rs1_id, rs2_id  in  REG_AW  ID-stage source registers
- rs1_used_id, rs2_used_id  in  1  ID-stage instruction actually reads rs1/rs2
- mc_busy_ex  in  1  multi-cycle EX unit not yet done
- branch_taken_ex  in  1  taken branch/jump resolved in EX
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- id_ex_write  out  1  ID/EX register enable
- id_ex_bubble  out  1  zero ID/EX control signals (insert NOP)
- if_id_flush  out  1  clear IF/ID to NOP
- stall_active  out  1  load stall in progress (FSM not in RUN)
- load_stall_cycles, mc_stall_cycles  out  PERF_W  perf counters (HAZARD_PERF_CNT_EN only)

## Operation
- hazard = mem_en_ex & mem_read_ex & rd_ex≠0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)). x0 and unused sources never stall.
- FSM states RUN and LOAD_WAIT. Down counter cnt has width $clog2(LOAD_LAT+1).
- Priority each cycle: branch_taken_ex > mc_busy_ex > load stall > run.
- Flush: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, id_ex_write=1. FSM goes to RUN and cnt=0.
- mc_busy_ex: pc_write=0, if_id_write=0, id_ex_write=0, id_ex_bubble=0. FSM and cnt hold.
- RUN with hazard: pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_write=1.
  - If LOAD_LAT>1: go to LOAD_WAIT with cnt=LOAD_LAT-1.
  - If LOAD_LAT=1: stay in RUN.
- LOAD_WAIT: same stall outputs as a RUN hazard. cnt decrements each cycle. At cnt==1 the next state is RUN. The hazard is not re-evaluated in LOAD_WAIT because EX holds a bubble.
- RUN without hazard: pc_write=1, if_id_write=1, id_ex_write=1, id_ex_bubble=0, if_id_flush=0.
- stall_active=1 exactly while state==LOAD_WAIT (registered).

## Timing
- Outputs are combinational from inputs and registered state in the same cycle. The stall starts in the detection cycle.
- Load-use hazard holds PC and IF/ID for exactly LOAD_LAT consecutive cycles.
- Reset (rst_n=0 at a clk edge): state=RUN, cnt=0, perf counters=0.
- While rst_n=0, outputs are forced to run values: pc_write=1, if_id_write=1, id_ex_write=1, id_ex_bubble=0, if_id_flush=0, stall_active=0.
- Reset asserted in mid LOAD_WAIT aborts the stall on the next edge.
- Simultaneous flush and hazard: flush wins and no stall follows.
- Simultaneous mc_busy_ex and hazard: freeze wins; the hazard is re-evaluated once mc_busy_ex drops.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds load_stall_cycles and mc_stall_cycles.
  - load_stall_cycles increments each cycle id_ex_bubble=1 due to a load.
  - mc_stall_cycles increments each cycle mc_busy_ex freezes the pipe.
  - Both saturate at 2^PERF_W-1 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- hazard_pkg: state enum typedef (RUN, LOAD_WAIT) and priority encoding constants.
- One sub-module, hazard_stall_timer: load/decrement/terminal-count down counter, parametrised by LOAD_LAT.

## Test plan
- LOAD_LAT=1, lw x5 in EX, ID reads rs1=x5 with rs1_used=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, then run values.
- LOAD_LAT=3, same hazard -> three consecutive stall cycles; stall_active=1 on cycles 2–3; RUN afterwards.
- rd_ex=0, or rs2 match with rs2_used_id=0 -> no stall.
- mc_busy_ex high for 4 cycles together with a load hazard -> 4 freeze cycles (id_ex_write=0), then LOAD_LAT stall cycles.
- branch_taken_ex together with a hazard -> if_id_flush=1, id_ex_bubble=1, pc_write=1, no stall next cycle.
- LOAD_LAT=3, rst_n=0 on the second stall cycle -> run values next cycle. With HAZARD_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// per-cycle action priority and the pipeline-control bundle driven by each
// action.
package hazard_pkg;

  // Load-stall FSM: RUN is the normal flow, LOAD_WAIT covers stall cycles 2..N.
  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } hz_state_e;

  // Per-cycle action. When several conditions are true in the same cycle,
  // the highest-priority one wins: flush > freeze > load stall > run.
  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_FREEZE = 2'd2,
    ACT_FLUSH  = 2'd3
  } hz_act_e;

  // Pipeline enables and clears produced for each action.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic id_ex_bubble;
    logic if_id_flush;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                     id_ex_bubble: 1'b0, if_id_flush: 1'b0};
  localparam hz_ctl_t CTL_LOAD   = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                                     id_ex_bubble: 1'b1, if_id_flush: 1'b0};
  localparam hz_ctl_t CTL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                     id_ex_bubble: 1'b0, if_id_flush: 1'b0};
  localparam hz_ctl_t CTL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                     id_ex_bubble: 1'b1, if_id_flush: 1'b1};

  // Resolve the competing requests of one cycle into a single action.
  function automatic hz_act_e sel_act(input logic flush, input logic freeze,
                                      input logic load_stall);
    if (flush)      return ACT_FLUSH;
    if (freeze)     return ACT_FREEZE;
    if (load_stall) return ACT_LOAD;
    return ACT_RUN;
  endfunction

  // Map an action to the pipeline control bundle.
  function automatic hz_ctl_t act_ctl(input hz_act_e act);
    hz_ctl_t ctl;
    case (act)
      ACT_FLUSH:  ctl = CTL_FLUSH;
      ACT_FREEZE: ctl = CTL_FREEZE;
      ACT_LOAD:   ctl = CTL_LOAD;
      default:    ctl = CTL_RUN;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/hazard_stall_timer.sv
// Down counter timing the remaining load-use stall cycles. It loads
// LOAD_LAT-1 on the detection cycle, decrements once per LOAD_WAIT cycle,
// and flags the final stall cycle (count of one).
module hazard_stall_timer #(
  parameter int LOAD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT - 1);

  logic [CW-1:0] cnt;

  // Count register: clear on reset/flush, load on detection, hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller between ID and EX/MEM of the in-order pipeline.
// Stalls IF/ID for LOAD_LAT cycles on a load-use hazard, freezes the front
// end and ID/EX while a multi-cycle EX unit is busy, and flushes younger
// instructions on a taken branch/jump resolved in EX.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall-cycle counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en_ex,
  input  logic              mem_read_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              rs1_used_id,
  input  logic              rs2_used_id,
  input  logic              mc_busy_ex,
  input  logic              branch_taken_ex,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_W-1:0] load_stall_cycles,
  output logic [PERF_W-1:0] mc_stall_cycles,
`endif
  output logic              stall_active
);

  // A single-cycle stall needs no LOAD_WAIT state at all.
  localparam bit MULTI_CYC = (LOAD_LAT > 1);

  hz_state_e state_q, state_d;
  hz_act_e   act;
  hz_ctl_t   ctl;
  logic      hazard;
  logic      t_load, t_dec, t_clr, t_last;

  // x0 never carries a dependency, and unused sources never stall.
  assign hazard = mem_en_ex && mem_read_ex && (rd_ex != '0) &&
                  ((rs1_used_id && (rs1_id == rd_ex)) ||
                   (rs2_used_id && (rs2_id == rd_ex)));

  hazard_stall_timer #(
    .LOAD_LAT (LOAD_LAT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (t_clr),
    .load  (t_load),
    .dec   (t_dec),
    .last  (t_last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, timer control and pipeline outputs. In LOAD_WAIT the EX
  // stage holds a bubble, so the hazard term is ignored until RUN returns.
  always_comb begin
    act     = sel_act(branch_taken_ex, mc_busy_ex, (state_q == LOAD_WAIT) || hazard);
    ctl     = act_ctl(act);
    state_d = state_q;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    t_clr   = 1'b0;
    case (act)
      ACT_FLUSH: begin
        state_d = RUN;
        t_clr   = 1'b1;
      end
      ACT_LOAD: begin
        if (state_q == LOAD_WAIT) begin
          t_dec = 1'b1;
          if (t_last) state_d = RUN;
        end else if (MULTI_CYC) begin
          state_d = LOAD_WAIT;
          t_load  = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rst_n) ctl = CTL_RUN;
  end

  assign pc_write     = ctl.pc_write;
  assign if_id_write  = ctl.if_id_write;
  assign id_ex_write  = ctl.id_ex_write;
  assign id_ex_bubble = ctl.id_ex_bubble;
  assign if_id_flush  = ctl.if_id_flush;
  assign stall_active = rst_n && (state_q == LOAD_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  // Increment that sticks at the all-ones value.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  // Stall-cycle counters: load bubbles and multi-cycle freezes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_stall_cycles <= '0;
      mc_stall_cycles   <= '0;
    end else begin
      if (act == ACT_LOAD)   load_stall_cycles <= sat_inc(load_stall_cycles);
      if (act == ACT_FREEZE) mc_stall_cycles   <= sat_inc(mc_stall_cycles);
    end
  end
`else
  logic unused_perf_w;
  assign unused_perf_w = ^PERF_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3)
// share one stimulus stream; a remaining-stall-cycles model predicts outputs.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_en_ex, mem_read_ex, mc_busy_ex, branch_taken_ex;
  logic [4:0] rd_ex, rs1_id, rs2_id;
  logic       rs1_used_id, rs2_used_id;

  logic pc1, ifid1, idex1, bub1, fl1, sa1;
  logic pc3, ifid3, idex3, bub3, fl3, sa3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] ld1, mc1;
  logic [3:0]  ld3, mc3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .PERF_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .mem_en_ex(mem_en_ex), .mem_read_ex(mem_read_ex),
    .rd_ex(rd_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .mc_busy_ex(mc_busy_ex), .branch_taken_ex(branch_taken_ex),
    .pc_write(pc1), .if_id_write(ifid1), .id_ex_write(idex1),
    .id_ex_bubble(bub1), .if_id_flush(fl1),
`ifdef HAZARD_PERF_CNT_EN
    .load_stall_cycles(ld1), .mc_stall_cycles(mc1),
`endif
    .stall_active(sa1));

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .PERF_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .mem_en_ex(mem_en_ex), .mem_read_ex(mem_read_ex),
    .rd_ex(rd_ex), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .mc_busy_ex(mc_busy_ex), .branch_taken_ex(branch_taken_ex),
    .pc_write(pc3), .if_id_write(ifid3), .id_ex_write(idex3),
    .id_ex_bubble(bub3), .if_id_flush(fl3),
`ifdef HAZARD_PERF_CNT_EN
    .load_stall_cycles(ld3), .mc_stall_cycles(mc3),
`endif
    .stall_active(sa3));

  // ---------------- behavioural model ----------------
  // rem = stall cycles still owed after the current one has been detected.
  int    rem1 = 0, rem3 = 0;
  longint pld1 = 0, pmc1 = 0, pld3 = 0, pmc3 = 0;
  localparam longint MAX1 = 64'hFFFF_FFFF;
  localparam longint MAX3 = 64'd15;

  function automatic bit hz();
    return mem_en_ex && mem_read_ex && (rd_ex != 0) &&
           ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
  endfunction

  // Expected {pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush, stall_active}
  function automatic logic [5:0] model_exp(int rem);
    logic sa;
    sa = (rem > 0);
    if (!rst_n)          return 6'b111000;
    if (branch_taken_ex) return {5'b11111, sa};
    if (mc_busy_ex)      return {5'b00000, sa};
    if (rem > 0 || hz()) return {5'b00110, sa};
    return 6'b111000;
  endfunction

  function automatic int next_rem(int rem, int lat);
    if (!rst_n || branch_taken_ex) return 0;
    if (mc_busy_ex)                return rem;
    if (rem > 0)                   return rem - 1;
    if (hz())                      return lat - 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      pld1 = 0; pmc1 = 0; pld3 = 0; pmc3 = 0;
    end else if (!branch_taken_ex) begin
      if (mc_busy_ex) begin
        if (pmc1 < MAX1) pmc1++;
        if (pmc3 < MAX3) pmc3++;
      end else begin
        if ((rem1 > 0 || hz()) && pld1 < MAX1) pld1++;
        if ((rem3 > 0 || hz()) && pld3 < MAX3) pld3++;
      end
    end
    rem1 = next_rem(rem1, 1);
    rem3 = next_rem(rem3, 3);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    check("lat1_outs", {26'd0, pc1, ifid1, idex1, bub1, fl1, sa1}, {26'd0, model_exp(rem1)});
    check("lat3_outs", {26'd0, pc3, ifid3, idex3, bub3, fl3, sa3}, {26'd0, model_exp(rem3)});
`ifdef HAZARD_PERF_CNT_EN
    check("lat1_ld_cnt", ld1, pld1[31:0]);
    check("lat1_mc_cnt", mc1, pmc1[31:0]);
    check("lat3_ld_cnt", {28'd0, ld3}, pld3[31:0]);
    check("lat3_mc_cnt", {28'd0, mc3}, pmc3[31:0]);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_en_ex = 0; mem_read_ex = 0; rd_ex = 0; rs1_id = 0; rs2_id = 0;
    rs1_used_id = 0; rs2_used_id = 0; mc_busy_ex = 0; branch_taken_ex = 0;
  endtask

  task automatic set_hz(input int rd, input int r1, input bit u1b, input int r2, input bit u2b);
    idle();
    mem_en_ex = 1; mem_read_ex = 1; rd_ex = 5'(rd);
    rs1_id = 5'(r1); rs1_used_id = u1b; rs2_id = 5'(r2); rs2_used_id = u2b;
  endtask

  function automatic logic [31:0] o3();
    return {26'd0, pc3, ifid3, idex3, bub3, fl3, sa3};
  endfunction
  function automatic logic [31:0] o1();
    return {26'd0, pc1, ifid1, idex1, bub1, fl1, sa1};
  endfunction

  initial begin
    int stalls;
    // Reset: run values while rst_n is low.
    rst_n = 0; idle();
    @(negedge clk);
    check("rst_lat1", o1(), 32'b111000);
    check("rst_lat3", o3(), 32'b111000);
    next_cyc();
    next_cyc(); rst_n = 1;
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_perf_ld3", {28'd0, ld3}, 32'd0);
`endif

    // Load-use hazard on rs1=x5.
    next_cyc(); set_hz(5, 5, 1, 0, 0);
    @(negedge clk);
    check("hz_lat1_c1", o1(), 32'b001100);
    check("hz_lat3_c1", o3(), 32'b001100);
    next_cyc(); idle();
    @(negedge clk);
    check("hz_lat1_c2", o1(), 32'b111000);
    check("hz_lat3_c2", o3(), 32'b001101);
    next_cyc();
    @(negedge clk);
    check("hz_lat3_c3", o3(), 32'b001101);
    next_cyc();
    @(negedge clk);
    check("hz_lat3_done", o3(), 32'b111000);

    // No stall for x0 or an unused matching source.
    next_cyc(); set_hz(0, 0, 1, 0, 1);
    @(negedge clk);
    check("x0_nostall", o3(), 32'b111000);
    next_cyc(); set_hz(7, 1, 1, 7, 0);
    @(negedge clk);
    check("rs2_unused_nostall", o3(), 32'b111000);

    // Freeze for 4 cycles with a pending hazard, then the full load stall.
    for (int i = 0; i < 4; i++) begin
      next_cyc(); set_hz(6, 0, 0, 6, 1); mc_busy_ex = 1;
      @(negedge clk);
      check("mc_freeze_lat3", o3(), 32'b000000);
    end
    next_cyc(); mc_busy_ex = 0;
    @(negedge clk);
    stalls = (pc3 == 0) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      next_cyc(); idle();
      @(negedge clk);
      if (pc3 == 0) stalls++;
    end
    check("mc_then_stall_cnt", 32'(stalls), 32'd3);

    // Branch with hazard: flush wins, no stall afterwards.
    next_cyc(); set_hz(5, 5, 1, 0, 0); branch_taken_ex = 1;
    @(negedge clk);
    check("flush_hz_lat3", o3(), 32'b111110);
    next_cyc(); idle();
    @(negedge clk);
    check("flush_after_lat3", o3(), 32'b111000);

    // Reset on the second stall cycle aborts the stall.
    next_cyc(); set_hz(5, 5, 1, 0, 0);
    @(negedge clk);
    next_cyc(); idle(); rst_n = 0;
    @(negedge clk);
    check("rst_mid_forced", o3(), 32'b111000);
    next_cyc(); rst_n = 1;
    @(negedge clk);
    check("rst_mid_after", o3(), 32'b111000);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_mid_ld3", {28'd0, ld3}, 32'd0);
    check("rst_mid_mc3", {28'd0, mc3}, 32'd0);
`endif

    // Randomised traffic with small register indices to provoke matches.
    for (int i = 0; i < 4000; i++) begin
      next_cyc();
      rst_n           = ($urandom_range(199) != 0);
      branch_taken_ex = ($urandom_range(99) < 8);
      mc_busy_ex      = ($urandom_range(99) < 15);
      mem_en_ex       = ($urandom_range(99) < 75);
      mem_read_ex     = ($urandom_range(99) < 65);
      rd_ex           = 5'($urandom_range(3));
      rs1_id          = 5'($urandom_range(3));
      rs2_id          = 5'($urandom_range(3));
      rs1_used_id     = 1'($urandom_range(1));
      rs2_used_id     = 1'($urandom_range(1));
    end

    next_cyc(); idle(); rst_n = 1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
